// File: rtl/alu_pkg.sv
// alu_pkg: shared command, state and width definitions for the ALU execution stage
package alu_pkg;
  localparam int ALU_BITS = 8;
  typedef enum logic [1:0] {OP_LDA, OP_LDB, OP_ADD, OP_SUB} alu_op_t;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} exec_state_t;
endpackage

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: accumulator/operand/flag registers and command FSM around an external add/subtract ALU
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int bits = ALU_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [bits-1:0] cmd_data,
  output logic [bits-1:0] alu_a,
  output logic [bits-1:0] alu_b,
  output logic            alu_sub,
  input  logic [bits-1:0] alu_result,
  input  logic            alu_carry,
  input  logic            alu_zero,
  output logic [bits-1:0] acc,
  output logic            flag_c,
  output logic            flag_z,
  output logic            done
);
  exec_state_t state, state_nxt;
  logic [bits-1:0] a_q, b_q;
  logic accept, is_arith;
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign accept = cmd_valid && cmd_ready;
  assign is_arith = (cmd_op == OP_ADD) || (cmd_op == OP_SUB);
  assign done = state == S_DONE;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign acc = a_q;
  always_comb begin
    state_nxt = state;
    state_nxt = state == S_EXEC ? S_DONE :
                state == S_DONE ? S_IDLE :
                accept ? (is_arith ? S_EXEC : S_DONE) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      alu_sub <= 1'b0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && cmd_op == OP_LDA) a_q <= cmd_data;
      if (accept && cmd_op == OP_LDB) b_q <= cmd_data;
      if (accept && is_arith) alu_sub <= cmd_op == OP_SUB;
      if (state == S_EXEC) begin
        a_q <= alu_result;
        flag_z <= alu_zero;
        // subtract leaves carry alone: the ALU carry output is meaningless there
        if (!alu_sub) flag_c <= alu_carry;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized and directed checks of alu_exec_unit against a behavioural model
module tb_alu_exec_unit;
  import alu_pkg::*;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_ready, alu_sub, alu_carry, alu_zero;
  logic flag_c, flag_z, done;
  logic [1:0] cmd_op = 0;
  logic [7:0] cmd_data = 0, alu_a, alu_b, alu_result, acc;
  logic [8:0] sum;
  logic [7:0] ref_a, ref_b;
  logic ref_c, ref_z;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  alu_exec_unit #(.bits(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sub(alu_sub), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .acc(acc), .flag_c(flag_c), .flag_z(flag_z), .done(done)
  );
  assign sum = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_result = alu_sub ? alu_a - alu_b : sum[7:0];
  assign alu_carry = alu_sub ? ~flag_c : sum[8];
  assign alu_zero = alu_result == 8'h00;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [1:0] op, input logic [7:0] d);
    int r;
    case (op)
      OP_LDA: ref_a = d;
      OP_LDB: ref_b = d;
      OP_ADD: begin
        r = int'(ref_a) + int'(ref_b);
        ref_a = r[7:0];
        ref_c = r > 255;
        ref_z = ref_a == 0;
      end
      default: begin
        r = int'(ref_a) - int'(ref_b) + 256;
        ref_a = r[7:0];
        ref_z = ref_a == 0;
      end
    endcase
  endtask
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] d);
    int k, w;
    w = 0;
    while (!cmd_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("ready", cmd_ready, 1);
    cmd_valid = 1;
    cmd_op = op;
    cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 0;
    cmd_op = 2'($urandom);
    cmd_data = 8'($urandom);
    model(op, d);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1 && op[1]) chk("alu_sub", alu_sub, op == OP_SUB);
    end while (!done && k < 8);
    chk("latency", k, op[1] ? 2 : 1);
    chk("acc", acc, ref_a);
    chk("flag_c", flag_c, ref_c);
    chk("flag_z", flag_z, ref_z);
    chk("alu_b", alu_b, ref_b);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int acc_n, done_n, r;
    ref_a = 0; ref_b = 0; ref_c = 0; ref_z = 0;
    cmd_valid = 1; cmd_op = OP_LDA; cmd_data = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_done", done, 0);
    end
    rst = 0;
    cmd_valid = 0;
    #1;
    chk("rst_acc", acc, 0);
    chk("rst_c", flag_c, 0);
    chk("rst_z", flag_z, 0);
    chk("rst_sub", alu_sub, 0);
    chk("rel_ready", cmd_ready, 1);
    do_cmd(OP_LDA, 8'h3C); do_cmd(OP_LDB, 8'h05); do_cmd(OP_ADD, 8'h00);
    chk("s2_acc", acc, 8'h41);
    do_cmd(OP_LDA, 8'hFF); do_cmd(OP_LDB, 8'h01); do_cmd(OP_ADD, 8'h00);
    chk("s3_wrap", {flag_c, flag_z, acc}, 10'h300);
    do_cmd(OP_LDA, 8'h10); do_cmd(OP_LDB, 8'h10); do_cmd(OP_SUB, 8'h00);
    chk("s3_sub", {flag_c, flag_z, acc}, 10'h300);
    do_cmd(OP_LDB, 8'h01); do_cmd(OP_SUB, 8'h00);
    chk("s4_sub", {flag_c, flag_z, acc}, 10'h2FF);
    do_cmd(OP_LDA, 8'h00);
    chk("s4_lda", {flag_c, flag_z, acc}, 10'h200);
    do_cmd(OP_LDA, 8'h01); do_cmd(OP_LDB, 8'h01);
    cmd_valid = 1; cmd_op = OP_ADD; cmd_data = 8'hAA;
    acc_n = 0; done_n = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 7) cmd_valid = 0;
      if (cmd_valid && cmd_ready) begin
        acc_n++;
        chk("hold_slot", i % 3, 0);
      end
      if (done) begin
        done_n++;
        model(OP_ADD, 8'h00);
        chk("hold_acc", acc, ref_a);
      end
      @(negedge clk);
    end
    chk("hold_accepts", acc_n, 3);
    chk("hold_dones", done_n, 3);
    chk("hold_final", acc, 8'h04);
    do_cmd(OP_LDA, 8'h20); do_cmd(OP_LDB, 8'h01);
    cmd_valid = 1; cmd_op = OP_ADD;
    @(posedge clk);
    #1 cmd_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_done", done, 0);
    @(negedge clk);
    chk("abort_done2", done, 0);
    chk("abort_state", {flag_c, flag_z, acc}, 10'h000);
    ref_a = 0; ref_b = 0; ref_c = 0; ref_z = 0;
    do_cmd(OP_LDA, 8'h07);
    chk("s6_acc", acc, 8'h07);
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 2));
      repeat (r) @(negedge clk);
      do_cmd(2'($urandom_range(0, 3)), 8'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Operand and flag register stage directly upstream and downstream of the 8-bit add/subtract ALU.
- Holds the accumulator (A) and operand (B) registers and drives the ALU's operand and select inputs.
- Captures the ALU result back into A, and the carry/zero outputs into a flags register.
- Accepts one command at a time from the sequencer over a valid/ready handshake.

Parameters:
- bits, 8, datapath width of A, B, cmd_data and the ALU interface.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  0=LDA, 1=LDB, 2=ADD, 3=SUB.
- cmd_data  in  bits  load value for LDA/LDB; ignored for ADD/SUB.
- alu_a  out  bits  ALU operand RA; equals A register.
- alu_b  out  bits  ALU operand RB; equals B register.
- alu_sub  out  1  ALU select s; 0=add, 1=subtract; registered.
- alu_result  in  bits  ALU out.
- alu_carry  in  1  ALU carry_out; sampled only for ADD.
- alu_zero  in  1  ALU zero_flag.
- acc  out  bits  A register value.
- flag_c  out  1  carry flag.
- flag_z  out  1  zero flag.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: A=0, B=0, flag_c=0, flag_z=0, alu_sub=0, done=0, state=IDLE. cmd_ready=0 in any cycle where rst=1.
- FSM states: IDLE, EXEC, DONE. Encoding comes from the package.
- cmd_ready = (state==IDLE) && !rst. A command is accepted on an edge where cmd_valid && cmd_ready.
- IDLE, accept LDA: A <= cmd_data; go to DONE.
- IDLE, accept LDB: B <= cmd_data; go to DONE.
- IDLE, accept ADD/SUB: alu_sub <= (cmd_op==SUB); go to EXEC.
- EXEC lasts one full cycle so the ALU settles on the registered A, B and alu_sub.
- End of EXEC (next edge): A <= alu_result and flag_z <= alu_zero; go to DONE.
- Carry flag: on ADD, flag_c <= alu_carry. On SUB, flag_c holds its previous value, because the ALU carry output is undefined for subtract.
- DONE: done=1 for exactly this cycle; unconditionally go to IDLE.
- Latency from the accept edge: LDA/LDB complete in 2 cycles (DONE is the cycle after accept). ADD/SUB complete in 3 cycles. Next accept is possible on the edge leaving DONE, i.e. the cycle after done.
- Flags change only on ADD/SUB. LDA/LDB never touch flag_c or flag_z.
- Arithmetic is modulo 2^bits, performed by the ALU. This block does no arithmetic and no width extension.
- cmd_valid held high while busy: ignored, no duplicate execution. A command still valid when IDLE returns is treated as a new command.
- cmd_op/cmd_data changing while busy: no effect.
- Reset in EXEC or DONE: abandon the operation. No writeback of A or flags, done stays 0, all registers return to reset values.
- done is combinational from state==DONE, with no other terms.
- alu_a/alu_b are combinational copies of the A/B registers. They are stable through EXEC because A and B are only written at accept (loads) and at end of EXEC.

Decomposition:
- Shared package alu_pkg:
  - alu_op_t enum (OP_LDA, OP_LDB, OP_ADD, OP_SUB, 2 bits)
  - exec_state_t enum (S_IDLE, S_EXEC, S_DONE)
  - localparam for the default width 8
- No sub-module. FSM, registers and flags live in one module. The ALU is instantiated alongside by the integrating top level, not inside this block.

Test Plan (bits=8):
1. Hold rst 3 cycles with cmd_valid=1 -> cmd_ready=0 throughout, no command accepted; after release, acc=0x00, flag_c=0, flag_z=0, cmd_ready=1.
2. LDA 0x3C, LDB 0x05, ADD -> acc=0x41, flag_c=0, flag_z=0; done pulses 2 cycles after ADD accept.
3. LDA 0xFF, LDB 0x01, ADD -> acc=0x00, flag_c=1, flag_z=1. Then LDA 0x10, LDB 0x10, SUB -> acc=0x00, flag_z=1, flag_c stays 1.
4. Directly after scenario 3, with acc=0x00 and B=0x10, issue LDB 0x01, then SUB -> acc=0xFF, flag_z=0, flag_c unchanged. LDA 0x00 afterwards leaves flag_c and flag_z unchanged.
5. Hold cmd_valid=1 with ADD continuously (A=0x01, B=0x01) for 7 cycles -> accepts only at IDLE, one accept per 3 cycles; acc goes 0x02, 0x03, 0x04; exactly one done per accept.
6. Accept ADD (A=0x20, B=0x01), assert rst during EXEC -> acc=0x00, no done pulse, flags=0; next LDA 0x07 completes normally with acc=0x07.
